// File: rtl/cj_cosim.sv
`default_nettype none
// ============================================================================
// Module   : cj_cosim
// Purpose  : End-of-test monitor for co-simulation. It snoops core stores to
//            the RISC-V tohost doubleword, counts committed-instruction
//            cycles, and lets the host force a tohost value.
//            tohost[0]=1 means done: 1 = pass, (code<<1)|1 = fail code.
// Ports    : clock, reset            - rising-edge clock, async active-high reset
//            wr_valid/addr/data/strb - core store beat (byte-lane enables)
//            commit_valid            - >=1 instruction retired this cycle
//            host_set_valid/value    - host override of tohost (bypasses lock)
//            tohost, done            - tohost register and tohost[0]
//            commit_count            - saturating retired-cycle counter
// Config   : `define CJ_WATCHDOG_EN to add the commit-stall watchdog, which
//            writes {STALL_CODE,1'b1} after STALL_LIMIT commit-free cycles.
// Revision : 1.0 - initial release
// ============================================================================
module cj_cosim #(
   parameter int unsigned            ADDR_W      = 32,
   parameter logic [ADDR_W-1:0]      TOHOST_ADDR = 32'h8000_1000,
   parameter int unsigned            STALL_LIMIT = 50000,
   parameter logic [62:0]            STALL_CODE  = 63'd2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [63:0]       wr_data,
   input  logic [7:0]        wr_strb,
   input  logic              commit_valid,
   input  logic              host_set_valid,
   input  logic [63:0]       host_set_value,
   output logic [63:0]       tohost,
   output logic              done,
   output logic [63:0]       commit_count
);

   logic [63:0] r_tohost;
   logic [63:0] r_commit_count;
   logic [63:0] w_next_tohost;
   logic        w_hit;
   logic        w_bus_wr;
   logic        w_wd_fire;

   // Doubleword match only; the byte offset inside the doubleword is ignored.
   assign w_hit    = wr_valid && (wr_addr[ADDR_W-1:3] == TOHOST_ADDR[ADDR_W-1:3]);
   // Once done, bus stores are locked out so the first completion value sticks.
   assign w_bus_wr = w_hit && !r_tohost[0];

`ifdef CJ_WATCHDOG_EN
   localparam int unsigned STALL_W =
      ($clog2(STALL_LIMIT + 1) > 17) ? $clog2(STALL_LIMIT + 1) : 17;

   logic [STALL_W-1:0] r_stall;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_stall <= '0;
      end else if (commit_valid || r_tohost[0] || host_set_valid) begin
         r_stall <= '0;
      end else if (r_stall != {STALL_W{1'b1}}) begin
         r_stall <= r_stall + 1'b1;
      end
   end

   // Lowest priority: host and bus writes in the same cycle take precedence.
   assign w_wd_fire = (r_stall == STALL_W'(STALL_LIMIT)) && !r_tohost[0]
                      && !host_set_valid && !w_bus_wr;

   logic w_unused_cfg;
   assign w_unused_cfg = ^wr_addr[2:0];
`else
   assign w_wd_fire = 1'b0;

   logic w_unused_cfg;
   assign w_unused_cfg = ^{wr_addr[2:0], STALL_CODE, 32'(STALL_LIMIT)};
`endif

   always_comb begin
      w_next_tohost = r_tohost;
      if (host_set_valid) begin
         w_next_tohost = host_set_value;
      end else if (w_bus_wr) begin
         for (int i = 0; i < 8; i++) begin
            if (wr_strb[i]) begin
               w_next_tohost[8*i +: 8] = wr_data[8*i +: 8];
            end
         end
      end else if (w_wd_fire) begin
         w_next_tohost = {STALL_CODE, 1'b1};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_tohost <= '0;
      end else begin
         r_tohost <= w_next_tohost;
      end
   end

   // Counts only while the test is running, and never wraps.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_commit_count <= '0;
      end else if (commit_valid && !r_tohost[0] && (r_commit_count != 64'hFFFF_FFFF_FFFF_FFFF)) begin
         r_commit_count <= r_commit_count + 64'd1;
      end
   end

   assign tohost       = r_tohost;
   assign done         = r_tohost[0];
   assign commit_count = r_commit_count;

endmodule
`default_nettype wire

// File: tb/tb_cj_cosim.sv
`default_nettype none
// ============================================================================
// Module   : tb_cj_cosim
// Purpose  : Directed self-checking bench for cj_cosim. Uses STALL_LIMIT=20 so
//            the watchdog (when CJ_WATCHDOG_EN is defined) fires quickly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cj_cosim;

   localparam logic [31:0] TH    = 32'h8000_1000;
   localparam int          LIMIT = 20;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        wr_valid = 1'b0;
   logic [31:0] wr_addr = '0;
   logic [63:0] wr_data = '0;
   logic [7:0]  wr_strb = '0;
   logic        commit_valid = 1'b0;
   logic        host_set_valid = 1'b0;
   logic [63:0] host_set_value = '0;
   logic [63:0] tohost;
   logic        done;
   logic [63:0] commit_count;

   int checks = 0;
   int errors = 0;

   cj_cosim #(
      .ADDR_W      (32),
      .TOHOST_ADDR (TH),
      .STALL_LIMIT (LIMIT),
      .STALL_CODE  (63'd2)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .wr_valid       (wr_valid),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .wr_strb        (wr_strb),
      .commit_valid   (commit_valid),
      .host_set_valid (host_set_valid),
      .host_set_value (host_set_value),
      .tohost         (tohost),
      .done           (done),
      .commit_count   (commit_count)
   );

   always #5 clock = ~clock;

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
      wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
      tick();
      wr_valid = 1'b0; wr_strb = '0;
   endtask

   task automatic host_set(input logic [63:0] v);
      host_set_valid = 1'b1; host_set_value = v;
      tick();
      host_set_valid = 1'b0;
   endtask

   task automatic commits(input int n);
      commit_valid = 1'b1;
      repeat (n) tick();
      commit_valid = 1'b0;
   endtask

   task automatic check_state(input string name, input logic [63:0] exp_th,
                              input logic exp_done, input logic [63:0] exp_cnt);
      checks++;
      if (tohost !== exp_th || done !== exp_done || commit_count !== exp_cnt) begin
         errors++;
         $display("FAIL %s: tohost=%h done=%b count=%0d, expected tohost=%h done=%b count=%0d",
                  name, tohost, done, commit_count, exp_th, exp_done, exp_cnt);
      end
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (tohost !== 64'd0 || done !== 1'b0 || commit_count !== 64'd0) begin
         errors++;
         $display("FAIL reset_initial: tohost=%h done=%b count=%0d, expected 0/0/0",
                  tohost, done, commit_count);
      end
      @(negedge clock); reset = 1'b0;
      tick();
      commits(3);
      host_set(64'd5);
      checks++;
      if (tohost !== 64'd5 || done !== 1'b1 || commit_count !== 64'd3) begin
         errors++;
         $display("FAIL pre_reset: tohost=%h done=%b count=%0d, expected 5/1/3",
                  tohost, done, commit_count);
      end
      // Assert reset between edges: outputs must clear without a clock edge.
      #2 reset = 1'b1;
      #1;
      checks++;
      if (tohost !== 64'd0 || done !== 1'b0 || commit_count !== 64'd0) begin
         errors++;
         $display("FAIL async_reset: tohost=%h done=%b count=%0d, expected 0/0/0",
                  tohost, done, commit_count);
      end
      @(negedge clock); reset = 1'b0;
   endtask

   task automatic test_pass_lock();
      bus_write(TH, 64'h1, 8'hFF);
      checks++;
      if (tohost !== 64'h1 || done !== 1'b1) begin
         errors++;
         $display("FAIL pass_write: tohost=%h done=%b, expected 1/1", tohost, done);
      end
      bus_write(TH, 64'h3, 8'hFF);
      checks++;
      if (tohost !== 64'h1) begin
         errors++;
         $display("FAIL lock: tohost=%h, expected 1", tohost);
      end
      host_set(64'd0);
      checks++;
      if (tohost !== 64'h0 || done !== 1'b0) begin
         errors++;
         $display("FAIL rearm: tohost=%h done=%b, expected 0/0", tohost, done);
      end
   endtask

   task automatic test_byte_merge();
      bus_write(TH + 32'd4, 64'hAABB_CCDD_EEFF_0010, 8'h0C);
      checks++;
      if (tohost !== 64'h0000_0000_EEFF_0000 || done !== 1'b0) begin
         errors++;
         $display("FAIL byte_merge: tohost=%h done=%b, expected 00000000eeff0000/0", tohost, done);
      end
      bus_write(TH + 32'd8, 64'h1, 8'hFF);
      checks++;
      if (tohost !== 64'h0000_0000_EEFF_0000) begin
         errors++;
         $display("FAIL addr_miss: tohost=%h, expected 00000000eeff0000", tohost);
      end
      bus_write(TH, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
      checks++;
      if (tohost !== 64'h0000_0000_EEFF_0000) begin
         errors++;
         $display("FAIL zero_strb: tohost=%h, expected 00000000eeff0000", tohost);
      end
      bus_write(TH + 32'd7, 64'h1122_3344_5566_7788, 8'h81);
      checks++;
      if (tohost !== 64'h1100_0000_EEFF_0088) begin
         errors++;
         $display("FAIL lane_0_7: tohost=%h, expected 11000000eeff0088", tohost);
      end
      host_set(64'd0);
   endtask

   task automatic test_priority();
      host_set_valid = 1'b1; host_set_value = 64'd5;
      bus_write(TH, 64'h1, 8'hFF);
      host_set_valid = 1'b0;
      checks++;
      if (tohost !== 64'd5 || done !== 1'b1) begin
         errors++;
         $display("FAIL host_over_bus: tohost=%h done=%b, expected 5/1", tohost, done);
      end
      host_set(64'd0);
      checks++;
      if (tohost !== 64'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL host_clear: tohost=%h done=%b, expected 0/0", tohost, done);
      end
      bus_write(TH, 64'h7, 8'hFF);
      checks++;
      if (tohost !== 64'h7 || done !== 1'b1) begin
         errors++;
         $display("FAIL bus_after_rearm: tohost=%h done=%b, expected 7/1", tohost, done);
      end
      host_set(64'd0);
   endtask

`ifdef CJ_WATCHDOG_EN
   task automatic test_watchdog();
      host_set(64'd0);
      repeat (LIMIT) tick();
      checks++;
      if (tohost !== 64'd0) begin
         errors++;
         $display("FAIL wd_early: tohost=%h, expected 0", tohost);
      end
      tick();
      checks++;
      if (tohost !== 64'd5 || done !== 1'b1) begin
         errors++;
         $display("FAIL wd_fire: tohost=%h done=%b, expected 5/1", tohost, done);
      end
      host_set(64'd0);
      repeat (LIMIT - 1) tick();
      commits(1);
      repeat (3) tick();
      checks++;
      if (tohost !== 64'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL wd_commit_rearm: tohost=%h done=%b, expected 0/0", tohost, done);
      end
   endtask
`else
   task automatic test_no_watchdog();
      host_set(64'd0);
      repeat (LIMIT + 10) tick();
      checks++;
      if (tohost !== 64'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL no_watchdog: tohost=%h done=%b, expected 0/0", tohost, done);
      end
   endtask
`endif

   task automatic test_commit_count();
      reset = 1'b1;
      #2;
      @(negedge clock); reset = 1'b0;
      commits(10);
      check_state("count_10", 64'd0, 1'b0, 64'd10);
      bus_write(TH, 64'h1, 8'hFF);
      commits(5);
      check_state("count_frozen", 64'd1, 1'b1, 64'd10);
      host_set(64'd0);
      commits(2);
      check_state("count_resume", 64'd0, 1'b0, 64'd12);
   endtask

   initial begin
      test_reset();
      test_pass_lock();
      test_byte_merge();
      test_priority();
`ifdef CJ_WATCHDOG_EN
      test_watchdog();
`else
      test_no_watchdog();
`endif
      test_commit_count();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
